// File: rtl/decoder_3_to_8_if.sv
// Select/enable bundle and decoded lines of the 3-to-8 decoder, with driver and decoder views.
interface decoder_3_to_8_if;
  logic       A;
  logic       B;
  logic       C;
  logic       en;
  logic [7:0] Y;

  modport master (
    output A,
    output B,
    output C,
    output en,
    input  Y
  );

  modport slave (
    input  A,
    input  B,
    input  C,
    input  en,
    output Y
  );
endinterface

// File: rtl/decoder_3_to_8.sv
// 3-to-8 one-hot decoder with enable; outputs are registered or reset-gated combinational.
module decoder_3_to_8 #(
  parameter int REGISTERED = 1
) (
  output logic Y7,
  output logic Y6,
  output logic Y5,
  output logic Y4,
  output logic Y3,
  output logic Y2,
  output logic Y1,
  output logic Y0,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic en,
  input  logic clk,
  input  logic rst
);

  logic [2:0] idx;
  logic [7:0] y_d;
  logic [7:0] y_out;

  assign idx = {A, B, C};

  always_comb begin
    y_d = '0;
    if (en) begin
      y_d[idx] = 1'b1;
    end
  end

  generate
    if (REGISTERED != 0) begin : g_reg
      logic [7:0] y_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          y_q <= '0;
        end else begin
          y_q <= y_d;
        end
      end

      assign y_out = y_q;
    end else begin : g_comb
      // No state in this mode: reset simply masks the live decode.
      assign y_out = rst ? '0 : y_d;
    end
  endgenerate

  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = y_out;

endmodule

// File: tb/tb_decoder_3_to_8.sv
// Randomized self-checking bench for decoder_3_to_8, covering registered and combinational builds.
module tb_decoder_3_to_8;

  logic       clk;
  logic       rst;
  logic [7:0] yc;
  logic       en_s;
  int unsigned idx_s;
  int unsigned vectors;
  int unsigned miscompares;

  decoder_3_to_8_if bus ();

  decoder_3_to_8 #(.REGISTERED(1)) u_reg (
    .Y7(bus.Y[7]), .Y6(bus.Y[6]), .Y5(bus.Y[5]), .Y4(bus.Y[4]),
    .Y3(bus.Y[3]), .Y2(bus.Y[2]), .Y1(bus.Y[1]), .Y0(bus.Y[0]),
    .A(bus.A), .B(bus.B), .C(bus.C), .en(bus.en),
    .clk(clk), .rst(rst)
  );

  decoder_3_to_8 #(.REGISTERED(0)) u_comb (
    .Y7(yc[7]), .Y6(yc[6]), .Y5(yc[5]), .Y4(yc[4]),
    .Y3(yc[3]), .Y2(yc[2]), .Y1(yc[1]), .Y0(yc[0]),
    .A(bus.A), .B(bus.B), .C(bus.C), .en(bus.en),
    .clk(clk), .rst(rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Reference: line n of eight is high exactly when enabled and n equals the select value.
  function automatic logic [7:0] ref_dec(input logic e, input int unsigned n);
    int unsigned v;
    v = e ? (2 ** n) : 0;
    return v[7:0];
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%b required=%b at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs between edges; the combinational build must follow at once.
  task automatic apply(input logic e, input int unsigned n);
    logic [2:0] s;
    en_s   = e;
    idx_s  = n;
    s      = n[2:0];
    bus.en = e;
    bus.A  = s[2];
    bus.B  = s[1];
    bus.C  = s[0];
    #1;
    check_val("comb", yc, rst ? 8'h00 : ref_dec(en_s, idx_s));
  endtask

  // Registered build captures the inputs present at the edge.
  task automatic tick(input string tag);
    logic [7:0] exp;
    exp = rst ? 8'h00 : ref_dec(en_s, idx_s);
    @(posedge clk);
    #1;
    check_val(tag, bus.Y, exp);
  endtask

  initial begin
    logic [7:0] prev;
    vectors     = 0;
    miscompares = 0;
    rst    = 1'b1;
    en_s   = 1'b0;
    idx_s  = 0;
    bus.en = 1'b0;
    bus.A  = 1'b0;
    bus.B  = 1'b0;
    bus.C  = 1'b0;

    #2;
    check_val("reset_reg", bus.Y, 8'h00);
    check_val("reset_comb", yc, 8'h00);

    apply(1'b1, 7);
    tick("reset_hold");
    #2;
    rst = 1'b0;
    #1;
    check_val("release_comb", yc, 8'h80);
    check_val("release_no_edge", bus.Y, 8'h00);

    apply(1'b0, 0);
    tick("en_gate_1");
    tick("en_gate_2");

    for (int unsigned i = 0; i < 8; i++) begin
      prev = bus.Y;
      apply(1'b1, i);
      check_val("sweep_latency", bus.Y, prev);
      tick("sweep");
    end

    apply(1'b1, 0); tick("dir_y0");
    apply(1'b1, 2); tick("dir_y2");
    apply(1'b1, 4); tick("dir_y4");
    apply(1'b1, 6); tick("dir_y6");
    apply(1'b0, 6); tick("dir_off");

    apply(1'b1, 5);
    tick("pre_rst_y5");
    #1;
    rst = 1'b1;
    #1;
    check_val("async_rst_reg", bus.Y, 8'h00);
    check_val("async_rst_comb", yc, 8'h00);
    tick("rst_held");
    #2;
    rst = 1'b0;
    #1;
    check_val("post_rst_no_edge", bus.Y, 8'h00);
    check_val("post_rst_comb", yc, 8'h20);
    tick("post_rst_y5");

    apply(1'b1, 3);
    check_val("comb_y3", yc, 8'h08);
    tick("reg_y3");

    for (int unsigned k = 0; k < 1000; k++) begin
      logic       e_prev;
      logic [7:0] pop;
      e_prev = en_s;
      apply(1'($urandom_range(0, 1)), $urandom_range(0, 7));
      pop = 8'($countones(yc));
      check_val("comb_onehot", pop, {7'd0, en_s});
      e_prev = en_s;
      tick("rand");
      pop = 8'($countones(bus.Y));
      check_val("reg_onehot", pop, {7'd0, e_prev});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decoder_3_to_8.md
DECODER_3_TO_8 -- requirements
Module: decoder_3_to_8

Interface
Parameters:
REQ-001 The block SHALL have parameter REGISTERED, default 1, meaning 1 = registered outputs and 0 = combinational outputs gated by reset.

Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port A, input, 1 bit: select bit 2 (MSB).
REQ-005 The block SHALL have port B, input, 1 bit: select bit 1.
REQ-006 The block SHALL have port C, input, 1 bit: select bit 0 (LSB).
REQ-007 The block SHALL have port en, input, 1 bit: decoder enable, active-high.
REQ-008 The block SHALL have ports Y7..Y0, each an output of 1 bit: decoded lines, active-high, with Yn corresponding to index n.
REQ-009 The port order SHALL be Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0, A, B, C, en, clk, rst, so that the first twelve positions match existing positional instantiations.

Function
REQ-010 The block SHALL form the select index as idx = {A,B,C}, an unsigned 3-bit value in the range 0..7.
REQ-011 When en=1, the decode value SHALL drive Y[idx] to 1 and all other Y outputs to 0, so the output is exactly one-hot.
REQ-012 When en=0, the decode value SHALL drive all eight Y outputs to 0, regardless of A, B and C.
REQ-013 When REGISTERED=1, the block SHALL hold the eight outputs in registers.
- The registers capture the decode value on each rising clk edge.
- Latency is exactly one clock cycle from an input change to the output change.
REQ-014 When REGISTERED=1, the outputs SHALL change only on a rising clk edge or on rst assertion, and SHALL be glitch-free between edges.
REQ-015 When REGISTERED=0, the outputs SHALL equal the decode value combinationally, with zero latency, and clk SHALL be unused.
REQ-016 The outputs SHALL never be multi-hot in any mode, at any clock edge, outside reset.
REQ-017 When en and the select bits change in the same cycle, the block SHALL use the new values for both: with REGISTERED=1 at the next edge, with REGISTERED=0 immediately.
REQ-018 Any X or Z on A, B, C or en is outside the supported input space, and no output value is defined for it.

Reset
REQ-019 Asserting rst SHALL force Y7..Y0 to 0 immediately, without waiting for a clk edge, in both modes.
REQ-020 While rst=1, Y7..Y0 SHALL remain 0 irrespective of clk, en, A, B and C.
REQ-021 With REGISTERED=1, after rst is deasserted the first nonzero output SHALL appear at the first rising clk edge at which en=1 and rst=0.
REQ-022 Asserting rst in the middle of operation, including between clock edges, SHALL clear the outputs; normal operation SHALL resume per REQ-021.
REQ-023 The block SHALL have no reset-dependent state other than the output registers.

Verification
REQ-024 The bench SHALL cover enable gating: with rst=0, en=0 and ABC=000 held for 2 edges, Y7..Y0 SHALL read 00000000.
REQ-025 The bench SHALL cover the exhaustive sweep: with en=1 and ABC stepped 000 through 111, one value per cycle, Y7..Y0 SHALL read 00000001, 00000010, ..., 10000000, each one cycle after its input when REGISTERED=1.
REQ-026 The bench SHALL cover a directed sequence:
- Steps: en=1 with ABC=000, then ABC=010, then ABC=100, then ABC=110, then en=0.
- Required outputs: Y0, then Y2, then Y4, then Y6 high in turn, then all 0 one cycle after en falls.
REQ-027 The bench SHALL cover asynchronous reset: with en=1 and ABC=101 (Y5=1), pulsing rst high mid-cycle SHALL drop Y to 00000000 before the next edge, and Y5 SHALL return at the first edge after rst deasserts.
REQ-028 The bench SHALL cover the one-hot invariant: under random en, A, B and C for at least 1000 cycles, the number of high Y lines SHALL be at most 1 every cycle, and SHALL equal en when rst=0 (REGISTERED=1: en of the previous cycle).
REQ-029 The bench SHALL cover combinational mode: with REGISTERED=0, en=1 and ABC=011, Y3 SHALL be 1 within the same timestep and no clk edge SHALL be required.
